// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   state_t   : responder FSM states (IDLE / WAIT / RESP)
//   LB..SW    : RV32I load/store funct3 width codes
//   f3_legal  : returns 1 when a funct3 code is a valid load or store width
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
        end else begin
            ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: combinational byte-lane logic for one memory access.
// Ports:
//   we        in   1=store, 0=load
//   funct3    in   RV32I width code
//   addr      in   byte address (full, used for lane select and range check)
//   wdata     in   right-aligned store data
//   rword     in   current contents of the addressed word
//   err       out  illegal funct3, misaligned or out-of-range
//   be        out  per-byte write enables (all zero for loads and errors)
//   wdata_pos out  store data replicated onto every lane it may occupy
//   rdata     out  extracted, sign/zero-extended load data (0 for stores/errors)
module dmem_lane_unit
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic        err,
    output logic [3:0]  be,
    output logic [31:0] wdata_pos,
    output logic [31:0] rdata
);

    logic        illegal;
    logic        misalign;
    logic        out_of_range;
    logic [31:0] word_idx;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        illegal      = !f3_legal(we, funct3);
        // funct3[1:0] encodes the size for every legal code: 00 byte, 01 half, 10 word
        misalign     = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        word_idx     = {2'b00, addr[31:2]};
        out_of_range = (word_idx >= 32'(DEPTH_WORDS));
        err          = illegal || misalign || out_of_range;

        case (addr[1:0])
            2'd0:    byte_val = rword[7:0];
            2'd1:    byte_val = rword[15:8];
            2'd2:    byte_val = rword[23:16];
            default: byte_val = rword[31:24];
        endcase
        half_val = addr[1] ? rword[31:16] : rword[15:0];

        be        = 4'b0000;
        wdata_pos = 32'h0;
        rdata     = 32'h0;

        if (!err) begin
            if (we) begin
                case (funct3[1:0])
                    2'b00: begin
                        be        = 4'b0001 << addr[1:0];
                        wdata_pos = {4{wdata[7:0]}};
                    end
                    2'b01: begin
                        be        = addr[1] ? 4'b1100 : 4'b0011;
                        wdata_pos = {2{wdata[15:0]}};
                    end
                    default: begin
                        be        = 4'b1111;
                        wdata_pos = wdata;
                    end
                endcase
            end else begin
                case (funct3)
                    LB:      rdata = {{24{byte_val[7]}}, byte_val};
                    LBU:     rdata = {24'h0, byte_val};
                    LH:      rdata = {{16{half_val[15]}}, half_val};
                    LHU:     rdata = {16'h0, half_val};
                    LW:      rdata = rword;
                    default: rdata = 32'h0;
                endcase
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory with a valid/ready request
// channel, programmable wait states and a valid/ready response channel.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (accept = valid && ready)
//   req_we/req_funct3/req_addr/req_wdata  request fields, latched at accept
//   rsp_valid/rsp_ready        response handshake (consume = valid && ready)
//   rsp_rdata/rsp_err          response payload, stable while in RESP
//   busy                       high whenever the FSM is not IDLE
//   dbg_state_o                current FSM state for observation
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and payload is held while valid.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        lat_we_q, lat_we_d;
    logic [2:0]  lat_funct3_q, lat_funct3_d;
    logic [31:0] lat_addr_q, lat_addr_d;
    logic [31:0] lat_wdata_q, lat_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept;
    logic        exec;
    logic        acc_we;
    logic [2:0]  acc_funct3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [AW-1:0] word_idx;
    logic [31:0] rword;
    logic        lane_err;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    assign accept = req_valid && req_ready;

    // With zero wait states the access executes in the accept cycle itself,
    // so the live request fields are used in IDLE; otherwise the latched copy.
    assign acc_we     = (state_q == IDLE) ? req_we     : lat_we_q;
    assign acc_funct3 = (state_q == IDLE) ? req_funct3 : lat_funct3_q;
    assign acc_addr   = (state_q == IDLE) ? req_addr   : lat_addr_q;
    assign acc_wdata  = (state_q == IDLE) ? req_wdata  : lat_wdata_q;

    assign word_idx = acc_addr[AW+1:2];
    assign rword    = mem_q[word_idx];

    dmem_lane_unit #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_lane (
        .we        (acc_we),
        .funct3    (acc_funct3),
        .addr      (acc_addr),
        .wdata     (acc_wdata),
        .rword     (rword),
        .err       (lane_err),
        .be        (lane_be),
        .wdata_pos (lane_wdata),
        .rdata     (lane_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_we_d     = lat_we_q;
        lat_funct3_d = lat_funct3_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        exec         = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    lat_we_d     = req_we;
                    lat_funct3_d = req_funct3;
                    lat_addr_d   = req_addr;
                    lat_wdata_d  = req_wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        exec    = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    exec    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (exec) begin
            rdata_d = lane_rdata;
            err_d   = lane_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            lat_we_q     <= 1'b0;
            lat_funct3_q <= 3'b000;
            lat_addr_q   <= 32'h0;
            lat_wdata_q  <= 32'h0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_we_q     <= lat_we_d;
            lat_funct3_q <= lat_funct3_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Storage is not reset. A store commits only on the edge entering RESP,
    // and a coincident reset suppresses it so an aborted store never lands.
    // lane_be is already zero for loads and errored accesses.
    always_ff @(posedge clk) begin
        if (!reset && exec) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign busy        = (state_q != IDLE);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: WAIT_CYCLES=2, index 1: WAIT_CYCLES=0
    logic [1:0]        reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0][2:0]   req_funct3;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [1:0][31:0]  rsp_rdata;
    logic [1:0]        rsp_err;
    logic [1:0]        busy;
    logic [1:0][1:0]   dbg_state;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0]), .dbg_state_o(dbg_state[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1]), .dbg_state_o(dbg_state[1])
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q0[$];   // {err, rdata}
    logic [32:0] exp_q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Monitors pop one expected response each time a response is consumed.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rsp_valid[0] === 1'b1 && rsp_ready[0] === 1'b1) begin
            if (exp_q0.size() == 0) begin
                fail_now("dut0_unexpected_rsp");
            end else begin
                e = exp_q0.pop_front();
                check("dut0_rdata", rsp_rdata[0], e[31:0]);
                check("dut0_err", {31'h0, rsp_err[0]}, {31'h0, e[32]});
            end
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (rsp_valid[1] === 1'b1 && rsp_ready[1] === 1'b1) begin
            if (exp_q1.size() == 0) begin
                fail_now("dut1_unexpected_rsp");
            end else begin
                e = exp_q1.pop_front();
                check("dut1_rdata", rsp_rdata[1], e[31:0]);
                check("dut1_err", {31'h0, rsp_err[1]}, {31'h0, e[32]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs(input int k);
        check($sformatf("dut%0d_rst_req_ready", k), {31'h0, req_ready[k]}, 32'h1);
        check($sformatf("dut%0d_rst_rsp_valid", k), {31'h0, rsp_valid[k]}, 32'h0);
        check($sformatf("dut%0d_rst_rdata", k), rsp_rdata[k], 32'h0);
        check($sformatf("dut%0d_rst_err", k), {31'h0, rsp_err[k]}, 32'h0);
        check($sformatf("dut%0d_rst_busy", k), {31'h0, busy[k]}, 32'h0);
    endtask

    // Presents a request and returns once the accept edge has passed (#1 after it).
    task automatic issue(input int k, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, output logic ok);
        int n;
        req_valid[k]  = 1'b1;
        req_we[k]     = we;
        req_funct3[k] = f3;
        req_addr[k]   = addr;
        req_wdata[k]  = wdata;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (n < 50);
        if (ok) begin
            @(posedge clk); #1;
        end
        // Garbage after accept: the responder must use its latched copy.
        req_valid[k]  = 1'b0;
        req_we[k]     = ~we;
        req_funct3[k] = 3'b111;
        req_addr[k]   = 32'hFFFF_FFFC;
        req_wdata[k]  = 32'h5A5A_5A5A;
    endtask

    // Counts edges from the accept edge (inclusive) until rsp_valid is seen.
    task automatic wait_rsp(input int k, output int lat);
        lat = 1;
        while (rsp_valid[k] !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_req(input int k, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int hold);
        logic ok;
        int   lat;
        if (k == 0) exp_q0.push_back({exp_err, exp_rd});
        else        exp_q1.push_back({exp_err, exp_rd});
        issue(k, we, f3, addr, wdata, ok);
        if (!ok) begin
            fail_now("req_accept_timeout");
            if (k == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
            return;
        end
        wait_rsp(k, lat);
        if (rsp_valid[k] !== 1'b1) begin
            fail_now("rsp_valid_timeout");
            if (k == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
            return;
        end
        check($sformatf("dut%0d_latency", k), 32'(lat), 32'(exp_lat));
        check($sformatf("dut%0d_req_ready_in_resp", k), {31'h0, req_ready[k]}, 32'h0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_rsp_valid", {31'h0, rsp_valid[k]}, 32'h1);
            check("hold_rdata", rsp_rdata[k], exp_rd);
            check("hold_err", {31'h0, rsp_err[k]}, {31'h0, exp_err});
            check("hold_req_ready", {31'h0, req_ready[k]}, 32'h0);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        check($sformatf("dut%0d_req_ready_after", k), {31'h0, req_ready[k]}, 32'h1);
        check($sformatf("dut%0d_rsp_valid_after", k), {31'h0, rsp_valid[k]}, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic ok;
        int   lat;
        reset      = 2'b11;
        req_valid  = '0;
        req_we     = '0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        reset = 2'b00;
        @(posedge clk); #1;

        // basic store / load, latency 3
        do_req(0, 1'b1, SW, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 0);
        do_req(0, 1'b0, LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 0);

        // sub-word store and extraction
        do_req(0, 1'b1, SB,  32'h11, 32'h0000_00AA, 32'h0, 1'b0, 3, 0);
        do_req(0, 1'b0, LW,  32'h10, 32'h0, 32'hDEAD_AAEF, 1'b0, 3, 0);
        do_req(0, 1'b0, LB,  32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0, 3, 0);
        do_req(0, 1'b0, LBU, 32'h11, 32'h0, 32'h0000_00AA, 1'b0, 3, 0);
        do_req(0, 1'b0, LH,  32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0, 3, 0);
        do_req(0, 1'b0, LHU, 32'h12, 32'h0, 32'h0000_DEAD, 1'b0, 3, 0);

        // error cases: misaligned, out of range, illegal funct3
        do_req(0, 1'b0, LW,     32'h12,  32'h0,         32'h0, 1'b1, 3, 0);
        do_req(0, 1'b1, SH,     32'h13,  32'h0000_1234, 32'h0, 1'b1, 3, 0);
        do_req(0, 1'b0, LW,     32'h400, 32'h0,         32'h0, 1'b1, 3, 0);
        do_req(0, 1'b0, 3'b011, 32'h10,  32'h0,         32'h0, 1'b1, 3, 0);
        do_req(0, 1'b1, 3'b100, 32'h13,  32'h0000_0055, 32'h0, 1'b1, 3, 0);
        do_req(0, 1'b1, SW,     32'h400, 32'h1111_1111, 32'h0, 1'b1, 3, 0);
        do_req(0, 1'b0, LW,     32'h10,  32'h0, 32'hDEAD_AAEF, 1'b0, 3, 0);

        // back-pressure on the response, then immediate next request
        do_req(0, 1'b0, LW,  32'h10, 32'h0, 32'hDEAD_AAEF, 1'b0, 3, 5);
        do_req(0, 1'b1, SW,  32'h14, 32'h1122_3344, 32'h0, 1'b0, 3, 0);
        do_req(0, 1'b1, SH,  32'h16, 32'h0000_BEEF, 32'h0, 1'b0, 3, 0);
        do_req(0, 1'b0, LW,  32'h14, 32'h0, 32'hBEEF_3344, 1'b0, 3, 0);
        do_req(0, 1'b0, LH,  32'h16, 32'h0, 32'hFFFF_BEEF, 1'b0, 3, 0);
        do_req(0, 1'b0, LB,  32'h14, 32'h0, 32'h0000_0044, 1'b0, 3, 0);
        do_req(0, 1'b0, LB,  32'h17, 32'h0, 32'hFFFF_FFBE, 1'b0, 3, 0);

        // reset during WAIT aborts an accepted store
        do_req(0, 1'b1, SW, 32'h20, 32'h0BAD_F00D, 32'h0, 1'b0, 3, 0);
        issue(0, 1'b1, SW, 32'h20, 32'h1234_5678, ok);
        if (!ok) fail_now("abort_accept");
        reset[0] = 1'b1;
        @(posedge clk); #1;
        reset[0] = 1'b0;
        check_reset_outputs(0);
        repeat (4) @(posedge clk);
        #1;
        do_req(0, 1'b0, LW, 32'h20, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 0);

        // reset during RESP drops the response
        issue(0, 1'b0, LW, 32'h10, 32'h0, ok);
        if (!ok) fail_now("drop_accept");
        wait_rsp(0, lat);
        check("drop_rsp_valid_before", {31'h0, rsp_valid[0]}, 32'h1);
        reset[0] = 1'b1;
        @(posedge clk); #1;
        reset[0] = 1'b0;
        check_reset_outputs(0);

        // zero wait states: latency 1
        do_req(1, 1'b1, SW, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 0);
        do_req(1, 1'b0, LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 0);
        do_req(1, 1'b0, LB, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 1, 0);
        do_req(1, 1'b0, LH, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        check("exp_q0_drained", 32'(exp_q0.size()), 32'h0);
        check("exp_q1_drained", 32'(exp_q1.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words in the storage array.
REQ-002 The module SHALL have parameter WAIT_CYCLES, default 2, wait states inserted between request accept and response (0 to 15 allowed).
REQ-003 The module SHALL have a single clock domain, with a synchronous, active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: req_valid  input  1  initiator presents a request.
REQ-007 Port: req_ready  output  1  responder accepts a request this cycle.
REQ-008 Port: req_we  input  1  1=store, 0=load.
REQ-009 Port: req_funct3  input  3  RV32I load/store width code.
REQ-010 Port: req_addr  input  32  byte address.
REQ-011 Port: req_wdata  input  32  store data, right-aligned (byte/half in low bits).
REQ-012 Port: rsp_valid  output  1  response available.
REQ-013 Port: rsp_ready  input  1  initiator consumes the response.
REQ-014 Port: rsp_rdata  output  32  load data, sign/zero-extended; 0 for stores and errors.
REQ-015 Port: rsp_err  output  1  misaligned, out-of-range or illegal funct3.
REQ-016 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP; req_ready=1 only in IDLE, and rsp_valid=1 only in RESP.
REQ-018 Accept SHALL occur when req_valid&&req_ready; at accept, we/funct3/addr/wdata are latched, and later input changes are ignored.
REQ-019 On accept, the next state SHALL be WAIT with counter=WAIT_CYCLES-1 when WAIT_CYCLES>0, else the access is executed and the next state is RESP.
REQ-020 In WAIT, the counter SHALL decrement each cycle; when counter==0, the access executes and the next state is RESP; accept-to-rsp_valid latency is WAIT_CYCLES+1 cycles.
REQ-021 Legal loads SHALL be 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; legal stores SHALL be 000 SB, 001 SH and 010 SW; any other code sets err.
REQ-022 Misalignment (halfword with addr[0]=1, word with addr[1:0]!=0) SHALL set err.
REQ-023 Out-of-range (addr[31:2] >= DEPTH_WORDS) SHALL set err.
REQ-024 Byte lane SHALL be addr[1:0]; a halfword occupies lane addr[1]; stores update only the addressed bytes, leaving other bytes of the word unchanged.
REQ-025 A load with sign extension SHALL replicate bit 7 (LB) or bit 15 (LH) of the extracted data; LBU/LHU zero-fill.
REQ-026 An errored access SHALL not modify the array and SHALL return rsp_rdata=0 with rsp_err=1.
REQ-027 Store write SHALL commit exactly once, on the cycle of transition into RESP.
REQ-028 In RESP, rsp_rdata/rsp_err SHALL hold stable while rsp_ready=0; when rsp_ready=1, the next state is IDLE.
REQ-029 A new request SHALL not be accepted in the same cycle as response consumption (req_ready asserts the following cycle).
REQ-030 A load following a store to the same address SHALL return the stored data.

Reset
REQ-031 On reset, state SHALL be IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
REQ-032 Reset during WAIT SHALL abort the access; an uncommitted store is never written.
REQ-033 Reset during RESP SHALL drop the response.
REQ-034 Storage array contents SHALL be retained across reset (not cleared).

Structure
REQ-035 Shared package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-036 Sub-module dmem_lane_unit (combinational) SHALL perform store byte-enable/data positioning, load extraction/extension, and alignment/legality error detection.
REQ-037 The FSM, counter, latched request and array SHALL reside in dmem_responder.

Verification
REQ-038 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF, err=0; rsp_valid exactly 3 cycles after each accept (WAIT_CYCLES=2).
REQ-039 After REQ-038, SB 0x11 data 0x000000AA, LW 0x10 -> 0xDEADAAEF; LB 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD.
REQ-040 LW 0x12, SH 0x13, LW 0x400 (DEPTH 256) and funct3=011 -> err=1, rdata=0; a following LW 0x10 shows the word unchanged.
REQ-041 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable and req_ready=0 throughout; next request accepted the cycle after rsp_ready=1.
REQ-042 Assert reset one cycle after accepting SW 0x20 data 0x12345678 -> all outputs at reset values next cycle; LW 0x20 returns its prior value.
REQ-043 Run REQ-038 with WAIT_CYCLES=0 -> accept-to-rsp_valid latency of 1 cycle.
